// File: rtl/maxpool2_line.sv
// 2x2 stride-2 signed max pooling over a raster pixel stream.
// Row pairs are joined through a half-width line buffer of horizontal maxima.
module maxpool2_line #(
  parameter int WIDTH = 16,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    sof,
  input  logic signed [WIDTH-1:0] x,
  output logic signed [WIDTH-1:0] out,
  output logic                    out_valid,
  output logic                    frame_done
);

  localparam int CW       = $clog2(IMG_W);
  localparam int RW       = $clog2(IMG_H);
  localparam int LB_DEPTH = IMG_W / 2;
  localparam int LBW      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_POOL_LAST = CW'(2 * (IMG_W / 2) - 1);
  localparam logic [RW-1:0] ROW_POOL_LAST = RW'(2 * (IMG_H / 2) - 1);
  localparam bit            W_ODD         = (IMG_W % 2) != 0;
  localparam bit            H_ODD         = (IMG_H % 2) != 0;

  logic [CW-1:0]           col, cur_col, col_next;
  logic [RW-1:0]           row, cur_row, row_next;
  logic signed [WIDTH-1:0] h;
  logic signed [WIDTH-1:0] hmax;
  logic signed [WIDTH-1:0] lb_rd;
  logic signed [WIDTH-1:0] pool;
  logic [LBW-1:0]          lb_idx;
  logic                    col_ign;
  logic                    row_ign;
  logic                    lb_we;

  logic signed [WIDTH-1:0] lb [LB_DEPTH];

  // sof forces the current pixel to the frame origin whatever the counters hold
  always_comb begin
    cur_col = sof ? '0 : col;
    cur_row = sof ? '0 : row;
  end

  always_comb begin
    col_next = cur_col + 1'b1;
    row_next = cur_row;
    if (cur_col == COL_LAST) begin
      col_next = '0;
      row_next = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
    end
  end

  // trailing odd column / odd row fall outside every 2x2 window
  always_comb begin
    col_ign = W_ODD && (cur_col == COL_LAST);
    row_ign = H_ODD && (cur_row == ROW_LAST);
  end

  always_comb begin
    lb_idx = LBW'(cur_col >> 1);
    lb_rd  = lb[lb_idx];
    hmax   = (x > h) ? x : h;
    pool   = (lb_rd > hmax) ? lb_rd : hmax;
    lb_we  = en && !reset && cur_col[0] && !cur_row[0] && !row_ign;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col        <= '0;
      row        <= '0;
      h          <= '0;
      out        <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (en) begin
        col <= col_next;
        row <= row_next;
        if (!cur_col[0] && !col_ign)
          h <= x;
        if (cur_col[0] && cur_row[0]) begin
          out        <= pool;
          out_valid  <= 1'b1;
          frame_done <= (cur_col == COL_POOL_LAST) && (cur_row == ROW_POOL_LAST);
        end
      end
    end
  end

  // line buffer is never reset; odd rows only read entries written by the even row above
  always_ff @(posedge clk) begin
    if (lb_we)
      lb[lb_idx] <= hmax;
  end

endmodule

// File: tb/tb_maxpool2_line.sv
// Self-checking bench: three geometries share one stimulus stream and are each
// compared against a whole-frame reference model every cycle.
module tb_maxpool2_line;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset = 1'b1;
  logic               en    = 1'b0;
  logic               sof   = 1'b0;
  logic signed [15:0] x     = '0;

  logic signed [15:0] dout   [3];
  logic               dvalid [3];
  logic               ddone  [3];

  maxpool2_line #(.WIDTH(16), .IMG_W(4), .IMG_H(2)) dut_a (
    .clk(clk), .reset(reset), .en(en), .sof(sof), .x(x),
    .out(dout[0]), .out_valid(dvalid[0]), .frame_done(ddone[0]));

  maxpool2_line #(.WIDTH(16), .IMG_W(5), .IMG_H(3)) dut_b (
    .clk(clk), .reset(reset), .en(en), .sof(sof), .x(x),
    .out(dout[1]), .out_valid(dvalid[1]), .frame_done(ddone[1]));

  maxpool2_line #(.WIDTH(16), .IMG_W(6), .IMG_H(4)) dut_c (
    .clk(clk), .reset(reset), .en(en), .sof(sof), .x(x),
    .out(dout[2]), .out_valid(dvalid[2]), .frame_done(ddone[2]));

  int n_checks = 0;
  int n_pass   = 0;
  int edge_no  = 0;

  // reference model: a full frame store per geometry, pooled from stored pixels
  int                 mw [3] = '{4, 5, 6};
  int                 mh [3] = '{2, 3, 4};
  int                 mrow [3];
  int                 mcol [3];
  logic signed [15:0] pix [3][8][8];
  logic signed [15:0] eout   [3];
  logic               evalid [3];
  logic               edone  [3];

  logic signed [15:0] rec_a_out[$];
  int                 rec_a_cyc[$];
  int                 rec_a_done[$];
  logic signed [15:0] rec_b_out[$];
  int                 rec_b_done[$];

  function automatic logic signed [15:0] max2(input logic signed [15:0] a, input logic signed [15:0] b);
    return (a > b) ? a : b;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic modelStep(input int k);
    int r, c;
    evalid[k] = 1'b0;
    edone[k]  = 1'b0;
    if (reset) begin
      mrow[k] = 0;
      mcol[k] = 0;
      eout[k] = '0;
    end else if (en) begin
      r = sof ? 0 : mrow[k];
      c = sof ? 0 : mcol[k];
      pix[k][r][c] = x;
      if ((r % 2 == 1) && (c % 2 == 1) && (r < 2 * (mh[k] / 2)) && (c < 2 * (mw[k] / 2))) begin
        eout[k]   = max2(max2(pix[k][r-1][c-1], pix[k][r-1][c]), max2(pix[k][r][c-1], pix[k][r][c]));
        evalid[k] = 1'b1;
        edone[k]  = (r == 2 * (mh[k] / 2) - 1) && (c == 2 * (mw[k] / 2) - 1);
      end
      c++;
      if (c == mw[k]) begin
        c = 0;
        r = (r == mh[k] - 1) ? 0 : r + 1;
      end
      mrow[k] = r;
      mcol[k] = c;
    end
  endtask

  task automatic checkOutput();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("dut%0d_out_valid", k), int'(dvalid[k]), int'(evalid[k]));
      check($sformatf("dut%0d_frame_done", k), int'(ddone[k]), int'(edone[k]));
      check($sformatf("dut%0d_out", k), int'(dout[k]), int'(eout[k]));
    end
    if (dvalid[0]) begin
      rec_a_out.push_back(dout[0]);
      rec_a_cyc.push_back(edge_no + 1);
      rec_a_done.push_back(int'(ddone[0]));
    end
    if (dvalid[1]) begin
      rec_b_out.push_back(dout[1]);
      rec_b_done.push_back(int'(ddone[1]));
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic s, input logic signed [15:0] v);
    @(negedge clk);
    reset = r;
    en    = e;
    sof   = s;
    x     = v;
    @(posedge clk);
    edge_no++;
    for (int k = 0; k < 3; k++) modelStep(k);
    #1;
    checkOutput();
  endtask

  task automatic clearRecords();
    rec_a_out.delete();
    rec_a_cyc.delete();
    rec_a_done.delete();
    rec_b_out.delete();
    rec_b_done.delete();
    edge_no = 0;
  endtask

  logic signed [15:0] frame_a [8] = '{16'sd1, 16'sd5, -16'sd3, 16'sd2, 16'sd4, 16'sd0, 16'sd7, -16'sd8};

  initial begin
    // reset wins over en/sof; then first pixel without sof must land at origin
    applyStimulus(1'b1, 1'b1, 1'b1, 16'sd77);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'sd0);
    clearRecords();
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0, frame_a[i]);
    check("basic_count", rec_a_out.size(), 2);
    if (rec_a_out.size() == 2) begin
      check("basic_out0", int'(rec_a_out[0]), 5);
      check("basic_out1", int'(rec_a_out[1]), 7);
      check("basic_cyc0", rec_a_cyc[0], 7);
      check("basic_cyc1", rec_a_cyc[1], 9);
      check("basic_done0", rec_a_done[0], 0);
      check("basic_done1", rec_a_done[1], 1);
    end

    // all-negative frame exercises the signed compare
    clearRecords();
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, i == 0, 16'(-100 + i));
    check("neg_count", rec_a_out.size(), 2);
    if (rec_a_out.size() == 2) begin
      check("neg_out0", int'(rec_a_out[0]), -95);
      check("neg_out1", int'(rec_a_out[1]), -93);
    end

    // bubbles between every pixel
    clearRecords();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, i == 0, frame_a[i]);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'($urandom));
    end
    check("bubble_count", rec_a_out.size(), 2);
    if (rec_a_out.size() == 2) begin
      check("bubble_out0", int'(rec_a_out[0]), 5);
      check("bubble_out1", int'(rec_a_out[1]), 7);
      check("bubble_cyc0", rec_a_cyc[0], 12);
      check("bubble_cyc1", rec_a_cyc[1], 16);
    end

    // odd geometry: trailing column and row never pooled
    clearRecords();
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b1, i == 0, 16'(i));
    check("odd_count", rec_b_out.size(), 2);
    if (rec_b_out.size() == 2) begin
      check("odd_out0", int'(rec_b_out[0]), 6);
      check("odd_out1", int'(rec_b_out[1]), 8);
      check("odd_done0", rec_b_done[0], 0);
      check("odd_done1", rec_b_done[1], 1);
    end

    // reset in the middle of a frame, then a full frame without sof
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, i == 0, 16'($urandom));
    applyStimulus(1'b1, 1'b1, 1'b0, 16'($urandom));
    for (int i = 0; i < 24; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'($urandom));

    // sof resync at the fourth pixel of a frame
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, i == 0, 16'($urandom));
    for (int i = 0; i < 48; i++) applyStimulus(1'b0, 1'b1, i == 0, 16'($urandom));

    // long randomized run with bubbles, occasional resync and reset
    for (int i = 0; i < 600; i++)
      applyStimulus($urandom_range(0, 250) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 80) == 0, 16'($urandom));

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
